// File: rtl/micro_seq_pkg.sv
// Shared types and constants for the microprogram sequencer.
// Dispatch table entries are 4-bit and zero-extended to the micro-address width.
package micro_seq_pkg;

  typedef enum logic [2:0] {
    SEQ   = 3'b000,
    DISP1 = 3'b001,
    DISP2 = 3'b010,
    FETCH = 3'b011,
    JUMP  = 3'b100,
    BRC   = 3'b101,
    CALL  = 3'b110,
    RET   = 3'b111
  } addr_ctl_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;

  localparam logic [3:0] D1_R   = 4'd6;
  localparam logic [3:0] D1_I   = 4'd8;
  localparam logic [3:0] D1_JAL = 4'd9;
  localparam logic [3:0] D1_B   = 4'd10;
  localparam logic [3:0] D1_LW  = 4'd2;
  localparam logic [3:0] D1_SW  = 4'd2;
  localparam logic [3:0] D2_LW  = 4'd3;
  localparam logic [3:0] D2_SW  = 4'd5;

endpackage

// File: rtl/micro_sequencer_if.sv
// Control-side bundle between the control-store ROM fields and the sequencer.
// The master drives selects and opcode; the slave returns upc and sticky flags.
interface micro_sequencer_if #(
  parameter int AW = 4
);
  import micro_seq_pkg::*;

  logic          stall;
  logic [6:0]    op;
  addr_ctl_e     addr_ctl;
  logic [AW-1:0] target;
  logic          cond;
  logic [AW-1:0] upc;
  logic          illegal_op;
  logic          stack_err;

  modport master (
    output stall, op, addr_ctl, target, cond,
    input  upc, illegal_op, stack_err
  );

  modport slave (
    input  stall, op, addr_ctl, target, cond,
    output upc, illegal_op, stack_err
  );

endinterface

// File: rtl/micro_dispatch_rom.sv
// Opcode dispatch table: combinational op -> {hit, addr}.
// A miss yields hit=0 and addr=0 so no X can reach the micro-PC.
module micro_dispatch_rom
  import micro_seq_pkg::*;
#(
  parameter int AW        = 4,
  parameter int TABLE_SEL = 1
) (
  input  logic [6:0]    op,
  output logic          hit,
  output logic [AW-1:0] addr
);

  logic [3:0] d;

  always_comb begin
    hit = 1'b1;
    d   = 4'd0;
    if (TABLE_SEL == 1) begin
      unique case (1'b1)
        (op == OP_R):   d = D1_R;
        (op == OP_I):   d = D1_I;
        (op == OP_JAL): d = D1_JAL;
        (op == OP_B):   d = D1_B;
        (op == OP_LW):  d = D1_LW;
        (op == OP_SW):  d = D1_SW;
        default:        hit = 1'b0;
      endcase
    end else begin
      unique case (1'b1)
        (op == OP_LW): d = D2_LW;
        (op == OP_SW): d = D2_SW;
        default:       hit = 1'b0;
      endcase
    end
    addr = hit ? AW'(d) : '0;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: micro-PC register, next-address mux,
// micro-subroutine return stack and sticky error flags.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int            AW          = 4,
  parameter int            STACK_DEPTH = 4,
  parameter logic [AW-1:0] FETCH_ADDR  = '0,
  parameter logic [AW-1:0] TRAP_ADDR   = '1
) (
  input logic               clk,
  input logic               reset,
  micro_sequencer_if.slave  bus
);

  localparam int SW = $clog2(STACK_DEPTH + 1);

  localparam logic [SW-1:0] SP_ONE  = SW'(1);
  localparam logic [SW-1:0] SP_FULL = SW'(STACK_DEPTH);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  logic [AW-1:0] upc_q, upc_d;
  logic [SW-1:0] sp_q, sp_d;
  logic          ill_q, ill_d;
  logic          serr_q, serr_d;
  logic [AW-1:0] stack_q [STACK_DEPTH];
  logic [AW-1:0] stack_d [STACK_DEPTH];

  logic [AW-1:0] inc;
  logic [AW-1:0] pop_val;
  logic [SW-1:0] sp_m1;
  logic          hit1, hit2;
  logic [AW-1:0] addr1, addr2;

  micro_dispatch_rom #(.AW(AW), .TABLE_SEL(1)) u_rom1 (
    .op   (bus.op),
    .hit  (hit1),
    .addr (addr1)
  );

  micro_dispatch_rom #(.AW(AW), .TABLE_SEL(2)) u_rom2 (
    .op   (bus.op),
    .hit  (hit2),
    .addr (addr2)
  );

  assign inc   = upc_q + PC_ONE;
  assign sp_m1 = sp_q - SP_ONE;

  // Mux-based stack read avoids index-width mismatches for odd depths.
  always_comb begin
    pop_val = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_m1 == SW'(i)) pop_val = stack_q[i];
    end
  end

  always_comb begin
    upc_d   = upc_q;
    sp_d    = sp_q;
    ill_d   = ill_q;
    serr_d  = serr_q;
    stack_d = stack_q;
    if (!bus.stall) begin
      unique case (bus.addr_ctl)
        SEQ:   upc_d = inc;
        DISP1: begin
          upc_d = hit1 ? addr1 : TRAP_ADDR;
          if (!hit1) ill_d = 1'b1;
        end
        DISP2: begin
          upc_d = hit2 ? addr2 : TRAP_ADDR;
          if (!hit2) ill_d = 1'b1;
        end
        FETCH: upc_d = FETCH_ADDR;
        JUMP:  upc_d = bus.target;
        BRC:   upc_d = bus.cond ? bus.target : inc;
        CALL: begin
          if (sp_q == SP_FULL) begin
            upc_d  = TRAP_ADDR;
            serr_d = 1'b1;
          end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (sp_q == SW'(i)) stack_d[i] = inc;
            end
            upc_d = bus.target;
            sp_d  = sp_q + SP_ONE;
          end
        end
        RET: begin
          if (sp_q == '0) begin
            upc_d  = TRAP_ADDR;
            serr_d = 1'b1;
          end else begin
            upc_d = pop_val;
            sp_d  = sp_m1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q  <= FETCH_ADDR;
      sp_q   <= '0;
      ill_q  <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      upc_q  <= upc_d;
      sp_q   <= sp_d;
      ill_q  <= ill_d;
      serr_q <= serr_d;
    end
  end

  // Stack contents are don't-care after reset; only sp is cleared.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.upc        = upc_q;
  assign bus.illegal_op = ill_q;
  assign bus.stack_err  = serr_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed scoreboard bench for micro_sequencer (AW=4, STACK_DEPTH=4).
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  logic clk;
  logic reset;

  micro_sequencer_if #(.AW(4)) bus ();

  micro_sequencer #(
    .AW          (4),
    .STACK_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] q_upc  [$];
  logic       q_ill  [$];
  logic       q_serr [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input logic [3:0] u, input logic i,
                            input logic s);
    q_upc.push_back(u);
    q_ill.push_back(i);
    q_serr.push_back(s);
  endtask

  task automatic chk(input string tag);
    logic [3:0] eu;
    logic       ei;
    logic       es;
    if (q_upc.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    eu = q_upc.pop_front();
    ei = q_ill.pop_front();
    es = q_serr.pop_front();
    checks++;
    assert (bus.upc === eu) else begin
      errors++;
      $error("FAIL %s upc: got %0d expected %0d", tag, bus.upc, eu);
    end
    checks++;
    assert (bus.illegal_op === ei) else begin
      errors++;
      $error("FAIL %s illegal_op: got %b expected %b", tag,
             bus.illegal_op, ei);
    end
    checks++;
    assert (bus.stack_err === es) else begin
      errors++;
      $error("FAIL %s stack_err: got %b expected %b", tag,
             bus.stack_err, es);
    end
  endtask

  task automatic step(input string tag, input addr_ctl_e ctl,
                      input logic [3:0] tgt, input logic c,
                      input logic st, input logic [6:0] opc,
                      input logic [3:0] eu, input logic ei,
                      input logic es);
    bus.addr_ctl = ctl;
    bus.target   = tgt;
    bus.cond     = c;
    bus.stall    = st;
    bus.op       = opc;
    expect_out(eu, ei, es);
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  initial begin
    reset        = 1'b1;
    bus.stall    = 1'b0;
    bus.op       = 7'd0;
    bus.addr_ctl = SEQ;
    bus.target   = 4'd0;
    bus.cond     = 1'b0;
    #3;
    expect_out(4'd0, 1'b0, 1'b0);
    chk("reset");
    @(negedge clk);
    reset = 1'b0;

    step("seq1", SEQ, 4'd0, 1'b0, 1'b0, 7'd0, 4'd1, 1'b0, 1'b0);
    step("seq2", SEQ, 4'd0, 1'b0, 1'b0, 7'd0, 4'd2, 1'b0, 1'b0);
    step("seq3", SEQ, 4'd0, 1'b0, 1'b0, 7'd0, 4'd3, 1'b0, 1'b0);
    step("jmp15", JUMP, 4'd15, 1'b0, 1'b0, 7'd0, 4'd15, 1'b0, 1'b0);
    step("wrap", SEQ, 4'd0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0);

    step("d1_r", DISP1, 4'd0, 1'b0, 1'b0, OP_R, 4'd6, 1'b0, 1'b0);
    step("d1_i", DISP1, 4'd0, 1'b0, 1'b0, OP_I, 4'd8, 1'b0, 1'b0);
    step("d1_jal", DISP1, 4'd0, 1'b0, 1'b0, OP_JAL, 4'd9, 1'b0, 1'b0);
    step("d1_b", DISP1, 4'd0, 1'b0, 1'b0, OP_B, 4'd10, 1'b0, 1'b0);
    step("d1_lw", DISP1, 4'd0, 1'b0, 1'b0, OP_LW, 4'd2, 1'b0, 1'b0);
    step("d2_lw", DISP2, 4'd0, 1'b0, 1'b0, OP_LW, 4'd3, 1'b0, 1'b0);
    step("d1_sw", DISP1, 4'd0, 1'b0, 1'b0, OP_SW, 4'd2, 1'b0, 1'b0);
    step("d2_sw", DISP2, 4'd0, 1'b0, 1'b0, OP_SW, 4'd5, 1'b0, 1'b0);

    step("d1_bad", DISP1, 4'd0, 1'b0, 1'b0, 7'b1110011,
         4'd15, 1'b1, 1'b0);
    step("fetch", FETCH, 4'd0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 1'b0);

    step("jmp4a", JUMP, 4'd4, 1'b0, 1'b0, 7'd0, 4'd4, 1'b1, 1'b0);
    step("brc_nt", BRC, 4'd9, 1'b0, 1'b0, 7'd0, 4'd5, 1'b1, 1'b0);
    step("jmp4b", JUMP, 4'd4, 1'b0, 1'b0, 7'd0, 4'd4, 1'b1, 1'b0);
    step("brc_t", BRC, 4'd9, 1'b1, 1'b0, 7'd0, 4'd9, 1'b1, 1'b0);
    step("stall", JUMP, 4'd2, 1'b0, 1'b1, 7'd0, 4'd9, 1'b1, 1'b0);

    step("jmp1", JUMP, 4'd1, 1'b0, 1'b0, 7'd0, 4'd1, 1'b1, 1'b0);
    step("call8", CALL, 4'd8, 1'b0, 1'b0, 7'd0, 4'd8, 1'b1, 1'b0);
    step("call12", CALL, 4'd12, 1'b0, 1'b0, 7'd0, 4'd12, 1'b1, 1'b0);
    step("ret9", RET, 4'd0, 1'b0, 1'b0, 7'd0, 4'd9, 1'b1, 1'b0);
    step("ret2", RET, 4'd0, 1'b0, 1'b0, 7'd0, 4'd2, 1'b1, 1'b0);

    step("nest1", CALL, 4'd5, 1'b0, 1'b0, 7'd0, 4'd5, 1'b1, 1'b0);
    step("nest2", CALL, 4'd7, 1'b0, 1'b0, 7'd0, 4'd7, 1'b1, 1'b0);
    step("nest3", CALL, 4'd10, 1'b0, 1'b0, 7'd0, 4'd10, 1'b1, 1'b0);
    step("nest4", CALL, 4'd12, 1'b0, 1'b0, 7'd0, 4'd12, 1'b1, 1'b0);
    step("nest5", CALL, 4'd3, 1'b0, 1'b0, 7'd0, 4'd15, 1'b1, 1'b1);
    step("pop4", RET, 4'd0, 1'b0, 1'b0, 7'd0, 4'd11, 1'b1, 1'b1);
    step("pop3", RET, 4'd0, 1'b0, 1'b0, 7'd0, 4'd8, 1'b1, 1'b1);
    step("pop2", RET, 4'd0, 1'b0, 1'b0, 7'd0, 4'd6, 1'b1, 1'b1);
    step("pop1", RET, 4'd0, 1'b0, 1'b0, 7'd0, 4'd3, 1'b1, 1'b1);
    step("ret_empty", RET, 4'd0, 1'b0, 1'b0, 7'd0, 4'd15, 1'b1, 1'b1);

    step("callw", CALL, 4'd4, 1'b0, 1'b0, 7'd0, 4'd4, 1'b1, 1'b1);
    step("call6", CALL, 4'd6, 1'b0, 1'b0, 7'd0, 4'd6, 1'b1, 1'b1);

    bus.addr_ctl = CALL;
    bus.target   = 4'd9;
    #2;
    reset = 1'b1;
    #1;
    expect_out(4'd0, 1'b0, 1'b0);
    chk("async_rst");
    bus.addr_ctl = RET;
    @(negedge clk);
    reset = 1'b0;

    step("ret_after_rst", RET, 4'd0, 1'b0, 1'b0, 7'd0,
         4'd15, 1'b0, 1'b1);
    step("sticky", SEQ, 4'd0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b1);

    if (q_upc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0",
               q_upc.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
